// File: rtl/fp_add_sequencer_if.sv
// Handshake bundle for the sequential FP adder: operand request channel
// and result channel, both valid/ready.
interface fp_add_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] floating1_in;
    logic [DATA_WIDTH-1:0] floating2_in;
    logic                  sub_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result_out;
    logic                  overflow_out;
    logic                  invalid_out;

    modport master (
        output in_valid,
        output floating1_in,
        output floating2_in,
        output sub_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result_out,
        input  overflow_out,
        input  invalid_out
    );

    modport slave (
        input  in_valid,
        input  floating1_in,
        input  floating2_in,
        input  sub_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result_out,
        output overflow_out,
        output invalid_out
    );
endinterface

// File: rtl/fp_add_sequencer.sv
// Multi-cycle single-precision add/subtract: capture/swap, bit-serial align,
// add, bit-serial normalise, pack. Truncating, denormals flushed to zero.
module fp_add_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    fp_add_sequencer_if.slave bus
);
    localparam int MANT_W    = MENT_WIDTH + 1;
    localparam int SUM_W     = MENT_WIDTH + 2;
    localparam int SHIFT_CAP = MENT_WIDTH + 3;
    localparam int CNT_W     = $clog2(SHIFT_CAP + 1);
    localparam int EXP_W     = EXPO_WIDTH + 1;

    localparam logic [EXPO_WIDTH-1:0] EXP_MAX  = {EXPO_WIDTH{1'b1}};
    localparam logic [EXPO_WIDTH-1:0] EXP_ZERO = {EXPO_WIDTH{1'b0}};
    localparam logic [MENT_WIDTH-1:0] MANT_ZERO = {MENT_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] QNAN =
        {1'b0, EXP_MAX, 1'b1, {(MENT_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  sign_q, sign_d;
    logic                  eff_sub_q, eff_sub_d;
    logic [EXP_W-1:0]      exp_q, exp_d;
    logic [MANT_W-1:0]     ma_q, ma_d;
    logic [MANT_W-1:0]     mb_q, mb_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  ovf_q, ovf_d;
    logic                  inv_q, inv_d;
    logic                  in_ready_q;
    logic                  out_valid_q;

    logic                  sa_s, sb_s;
    logic [EXPO_WIDTH-1:0] ea_s, eb_s, big_e_s, small_e_s, diff_s;
    logic [MENT_WIDTH-1:0] fa_s, fb_s, big_f_s, small_f_s;
    logic                  za_s, zb_s, ia_s, ib_s, na_s, nb_s, swap_s;
    logic [EXP_W-1:0]      exp_inc_s, exp_dec_s;

    // Operand unpack and magnitude ordering, evaluated on the live inputs.
    always_comb begin
        sa_s      = bus.floating1_in[DATA_WIDTH-1];
        sb_s      = bus.floating2_in[DATA_WIDTH-1] ^ bus.sub_in;
        ea_s      = bus.floating1_in[DATA_WIDTH-2 -: EXPO_WIDTH];
        eb_s      = bus.floating2_in[DATA_WIDTH-2 -: EXPO_WIDTH];
        fa_s      = bus.floating1_in[MENT_WIDTH-1:0];
        fb_s      = bus.floating2_in[MENT_WIDTH-1:0];
        za_s      = (ea_s == EXP_ZERO);
        zb_s      = (eb_s == EXP_ZERO);
        ia_s      = (ea_s == EXP_MAX) && (fa_s == MANT_ZERO);
        ib_s      = (eb_s == EXP_MAX) && (fb_s == MANT_ZERO);
        na_s      = (ea_s == EXP_MAX) && (fa_s != MANT_ZERO);
        nb_s      = (eb_s == EXP_MAX) && (fb_s != MANT_ZERO);
        swap_s    = (eb_s > ea_s) || ((eb_s == ea_s) && (fb_s > fa_s));
        big_e_s   = swap_s ? eb_s : ea_s;
        small_e_s = swap_s ? ea_s : eb_s;
        big_f_s   = swap_s ? fb_s : fa_s;
        small_f_s = swap_s ? fa_s : fb_s;
        diff_s    = big_e_s - small_e_s;
    end

    // Next-state and datapath updates for every phase of the operation.
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        exp_d     = exp_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        inv_d     = inv_q;
        exp_inc_s = exp_q + EXP_W'(1);
        exp_dec_s = exp_q - EXP_W'(1);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    ovf_d     = 1'b0;
                    inv_d     = 1'b0;
                    sign_d    = swap_s ? sb_s : sa_s;
                    eff_sub_d = sa_s ^ sb_s;
                    exp_d     = {1'b0, big_e_s};
                    ma_d      = {1'b1, big_f_s};
                    mb_d      = {1'b1, small_f_s};
                    if (diff_s > EXPO_WIDTH'(SHIFT_CAP)) begin
                        cnt_d = CNT_W'(SHIFT_CAP);
                    end else begin
                        cnt_d = diff_s[CNT_W-1:0];
                    end
                    // Specials never touch the serial datapath.
                    state_d = DONE;
                    if (na_s || nb_s || (ia_s && ib_s && (sa_s != sb_s))) begin
                        result_d = QNAN;
                        inv_d    = 1'b1;
                    end else if (ia_s) begin
                        result_d = {sa_s, EXP_MAX, MANT_ZERO};
                    end else if (ib_s) begin
                        result_d = {sb_s, EXP_MAX, MANT_ZERO};
                    end else if (za_s && zb_s) begin
                        result_d = {sa_s & sb_s, {(DATA_WIDTH-1){1'b0}}};
                    end else if (za_s) begin
                        result_d = {sb_s, bus.floating2_in[DATA_WIDTH-2:0]};
                    end else if (zb_s) begin
                        result_d = bus.floating1_in;
                    end else begin
                        state_d = ALIGN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ALIGN: begin
                if (cnt_q == CNT_W'(0)) begin
                    state_d = ADD;
                end else begin
                    mb_d  = mb_q >> 1;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ADD: begin
                if (eff_sub_q) begin
                    sum_d = {1'b0, ma_q} - {1'b0, mb_q};
                end else begin
                    sum_d = {1'b0, ma_q} + {1'b0, mb_q};
                end
                state_d = NORM;
            end
            NORM: begin
                if (sum_q[SUM_W-1]) begin
                    state_d = DONE;
                    if (exp_inc_s >= {1'b0, EXP_MAX}) begin
                        result_d = {sign_q, EXP_MAX, MANT_ZERO};
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = {sign_q, exp_inc_s[EXPO_WIDTH-1:0], sum_q[MENT_WIDTH:1]};
                    end
                end else if (sum_q == {SUM_W{1'b0}}) begin
                    state_d  = DONE;
                    result_d = {DATA_WIDTH{1'b0}};
                end else if (sum_q[MENT_WIDTH]) begin
                    state_d  = DONE;
                    result_d = {sign_q, exp_q[EXPO_WIDTH-1:0], sum_q[MENT_WIDTH-1:0]};
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_dec_s;
                    // Underflow below the smallest normal flushes to +0.
                    if (exp_dec_s == {EXP_W{1'b0}}) begin
                        state_d  = DONE;
                        result_d = {DATA_WIDTH{1'b0}};
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            exp_q       <= {EXP_W{1'b0}};
            ma_q        <= {MANT_W{1'b0}};
            mb_q        <= {MANT_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            sum_q       <= {SUM_W{1'b0}};
            result_q    <= {DATA_WIDTH{1'b0}};
            ovf_q       <= 1'b0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            eff_sub_q   <= eff_sub_d;
            exp_q       <= exp_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            inv_q       <= inv_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.result_out   = result_q;
    assign bus.overflow_out = ovf_q;
    assign bus.invalid_out  = inv_q;
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Bench for fp_add_sequencer: directed spec vectors, backpressure, reset
// mid-operation, and randomized operands against an arithmetic reference.
module tb_fp_add_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fp_add_sequencer_if #(.DATA_WIDTH(32)) bus ();

    fp_add_sequencer #(
        .DATA_WIDTH(32),
        .MENT_WIDTH(23),
        .EXPO_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference: IEEE decode, truncating align by the capped exponent gap,
    // then normalise by leading-one position. Latency from the phase rules.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic sub, output logic [31:0] res,
                                      output logic ovf, output logic inv, output int lat);
        logic sa, sb, sh;
        int   ea, eb, fa, fb, eh, el, mh, ml, d, sum, n, e;
        logic [31:0] pk;
        logic [7:0]  e8;
        sa = a[31];
        sb = b[31] ^ sub;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = int'(a[22:0]);
        fb = int'(b[22:0]);
        ovf = 1'b0;
        inv = 1'b0;
        lat = 1;
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) ||
            (ea == 255 && eb == 255 && sa != sb)) begin
            res = 32'h7FC00000;
            inv = 1'b1;
        end else if (ea == 255) begin
            res = {sa, 8'hFF, 23'd0};
        end else if (eb == 255) begin
            res = {sb, 8'hFF, 23'd0};
        end else if (ea == 0 && eb == 0) begin
            res = {sa & sb, 31'd0};
        end else if (ea == 0) begin
            res = {sb, b[30:0]};
        end else if (eb == 0) begin
            res = a;
        end else begin
            if (b[30:0] > a[30:0]) begin
                sh = sb; eh = eb; el = ea; mh = fb + (1 << 23); ml = fa + (1 << 23);
            end else begin
                sh = sa; eh = ea; el = eb; mh = fa + (1 << 23); ml = fb + (1 << 23);
            end
            d = eh - el;
            if (d > 26) d = 26;
            ml = ml >> d;
            sum = (sa == sb) ? (mh + ml) : (mh - ml);
            lat = 3 + d;
            if (sum == 0) begin
                res = 32'd0;
                lat = lat + 1;
            end else if (sum >= (1 << 24)) begin
                lat = lat + 1;
                e = eh + 1;
                if (e >= 255) begin
                    res = {sh, 8'hFF, 23'd0};
                    ovf = 1'b1;
                end else begin
                    pk = sum >> 1;
                    e8 = 8'(e);
                    res = {sh, e8, pk[22:0]};
                end
            end else begin
                n = 0;
                while (((sum << n) & (1 << 23)) == 0) n++;
                if (n >= eh) begin
                    res = 32'd0;
                    lat = lat + eh;
                end else begin
                    pk = sum << n;
                    e8 = 8'(eh - n);
                    res = {sh, e8, pk[22:0]};
                    lat = lat + n + 1;
                end
            end
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 15);
        case (k)
            0: v[30:23] = 8'd0;
            1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
            3: v[30:23] = 8'($urandom_range(250, 254));
            4: v[30:23] = 8'($urandom_range(1, 4));
            default: v[30:23] = 8'($urandom_range(110, 140));
        endcase
        return v;
    endfunction

    // Present one operand pair and hold it until accepted; scrambles inputs after.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         output logic ok);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ok = bus.in_ready;
        bus.floating1_in = a;
        bus.floating2_in = b;
        bus.sub_in       = sub;
        bus.in_valid     = ok;
        @(posedge clk); #1;
        bus.in_valid     = 1'b0;
        bus.floating1_in = $urandom;
        bus.floating2_in = $urandom;
        bus.sub_in       = 1'($urandom_range(0, 1));
    endtask

    // Cycles from acceptance until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int cycles);
        cycles = 1;
        while (!bus.out_valid && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!bus.out_valid) cycles = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        bus.floating1_in = 32'h3F800000;
        bus.floating2_in = 32'h3F800000;
        bus.sub_in = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if ({bus.in_ready, bus.out_valid, bus.overflow_out, bus.invalid_out} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_ctrl: got rdy/vld/ovf/inv=%b, want 1000",
                     {bus.in_ready, bus.out_valid, bus.overflow_out, bus.invalid_out});
        end
        total++;
        if (bus.result_out !== 32'd0) begin
            bad++;
            $display("FAIL reset_result: got %h want 00000000", bus.result_out);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] va [14] = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h40490FDB,
                                 32'h7F800000, 32'h7F7FFFFF, 32'h80000000, 32'h00000000,
                                 32'h7FC00001, 32'h4B000000, 32'h7F000000, 32'h00800000,
                                 32'h3F800000, 32'h7F800000};
        logic [31:0] vb [14] = '{32'h3F800000, 32'h3F000000, 32'h3F800000, 32'h40490FDB,
                                 32'hFF800000, 32'h7F7FFFFF, 32'h80000000, 32'h3F800000,
                                 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00C00000,
                                 32'hBF800000, 32'h3F800000};
        logic        vs [14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] vr [14] = '{32'h40000000, 32'h40600000, 32'h3F000000, 32'h00000000,
                                 32'h7FC00000, 32'h7F800000, 32'h80000000, 32'hBF800000,
                                 32'h7FC00000, 32'h4B000001, 32'h7F000000, 32'h00000000,
                                 32'h00000000, 32'h7F800000};
        logic [1:0]  vf [14] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00,
                                 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        int          vl [14] = '{4, 6, 5, 4, 1, 4, 1, 1, 1, 27, 30, 4, 4, 1};
        logic ok;
        int lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            issue(va[i], vb[i], vs[i], ok);
            wait_valid(lat);
            total++;
            if (!ok || lat != vl[i]) begin
                bad++;
                $display("FAIL dir%0d_latency: got %0d want %0d (accepted=%b)", i, lat, vl[i], ok);
            end
            total++;
            if (bus.result_out !== vr[i] || {bus.overflow_out, bus.invalid_out} !== vf[i]) begin
                bad++;
                $display("FAIL dir%0d_result: got %h ovf/inv=%b want %h ovf/inv=%b", i,
                         bus.result_out, {bus.overflow_out, bus.invalid_out}, vr[i], vf[i]);
            end
            @(posedge clk); #1;
            total++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL dir%0d_release: got vld=%b rdy=%b want vld=0 rdy=1",
                         i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        int lat;
        int extra;
        bus.out_ready = 1'b0;
        issue(32'h40400000, 32'h3F000000, 1'b0, ok);
        wait_valid(lat);
        total++;
        if (!ok || lat != 6 || bus.result_out !== 32'h40600000) begin
            bad++;
            $display("FAIL bp_first: got lat=%0d res=%h want lat=6 res=40600000", lat, bus.result_out);
        end
        for (int i = 0; i < 5; i++) begin
            bus.floating1_in = 32'h3F800000;
            bus.floating2_in = 32'h3F800000;
            bus.in_valid = (i == 2);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            total++;
            if ({bus.out_valid, bus.in_ready, bus.overflow_out, bus.invalid_out} !== 4'b1000 ||
                bus.result_out !== 32'h40600000) begin
                bad++;
                $display("FAIL bp_hold%0d: got vld/rdy/ovf/inv=%b res=%h want 1000 res=40600000", i,
                         {bus.out_valid, bus.in_ready, bus.overflow_out, bus.invalid_out},
                         bus.result_out);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL bp_ignored_pulse: got %0d valid cycles want 0", extra);
        end
    endtask

    task automatic test_reset_mid_align();
        logic ok;
        int lat;
        int extra;
        bus.out_ready = 1'b1;
        issue(32'h4B000000, 32'h3F800000, 1'b0, ok);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (!ok || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_state: got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_valid) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL midreset_discard: got %0d valid cycles want 0", extra);
        end
        issue(32'h3F800000, 32'h3F800000, 1'b0, ok);
        wait_valid(lat);
        total++;
        if (!ok || lat != 4 || bus.result_out !== 32'h40000000) begin
            bad++;
            $display("FAIL midreset_after: got lat=%0d res=%h want lat=4 res=40000000", lat, bus.result_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] a, b, er;
        logic s, eo, ei, ok;
        int el, lat, hold;
        for (int i = 0; i < 400; i++) begin
            a = rand_operand();
            b = rand_operand();
            case ($urandom_range(0, 3))
                0: b = {1'($urandom_range(0, 1)), a[30:23], 23'($urandom)};
                1: b = a ^ {9'd0, 23'($urandom_range(0, 255))};
                default: b = b;
            endcase
            s = 1'($urandom_range(0, 1));
            ref_model(a, b, s, er, eo, ei, el);
            hold = $urandom_range(0, 3);
            bus.out_ready = (hold == 0);
            issue(a, b, s, ok);
            wait_valid(lat);
            total++;
            if (!ok || lat != el) begin
                bad++;
                $display("FAIL rnd%0d_latency: %h %s %h got %0d want %0d", i, a, s ? "-" : "+", b, lat, el);
            end
            total++;
            if (bus.result_out !== er || bus.overflow_out !== eo || bus.invalid_out !== ei) begin
                bad++;
                $display("FAIL rnd%0d_result: %h %s %h got %h ovf=%b inv=%b want %h ovf=%b inv=%b",
                         i, a, s ? "-" : "+", b, bus.result_out, bus.overflow_out,
                         bus.invalid_out, er, eo, ei);
            end
            if (hold != 0) begin
                repeat (hold) begin @(posedge clk); #1; end
                total++;
                if (bus.out_valid !== 1'b1 || bus.result_out !== er) begin
                    bad++;
                    $display("FAIL rnd%0d_hold: got vld=%b res=%h want vld=1 res=%h",
                             i, bus.out_valid, bus.result_out, er);
                end
                bus.out_ready = 1'b1;
            end
            @(posedge clk); #1;
            total++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL rnd%0d_release: got vld=%b rdy=%b want vld=0 rdy=1",
                         i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.floating1_in = 32'd0;
        bus.floating2_in = 32'd0;
        bus.sub_in = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_align();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
